// File: rtl/logic_pkg.sv
// logic_pkg: op codes and FSM states shared by the bitwise logic unit
package logic_pkg;
  localparam logic [2:0] LOP_AND  = 3'd0;
  localparam logic [2:0] LOP_OR   = 3'd1;
  localparam logic [2:0] LOP_NOR  = 3'd2;
  localparam logic [2:0] LOP_XOR  = 3'd3;
  localparam logic [2:0] LOP_NAND = 3'd4;
  localparam logic [2:0] LOP_XNOR = 3'd5;
  localparam logic [2:0] LOP_ANDN = 3'd6;
  localparam logic [2:0] LOP_ORN  = 3'd7;
  typedef enum logic [1:0] {LU_IDLE, LU_RUN, LU_DONE} lu_state_e;
endpackage

// File: rtl/logic_slice.sv
// logic_slice: combinational bitwise op on one SLICE-bit chunk
module logic_slice
  import logic_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a_slice,
  input  logic [SLICE-1:0] b_slice,
  output logic [SLICE-1:0] c_slice
);
  // select the requested bitwise function
  always_comb
    c_slice = op == LOP_AND  ? a_slice & b_slice :
              op == LOP_OR   ? a_slice | b_slice :
              op == LOP_NOR  ? ~(a_slice | b_slice) :
              op == LOP_XOR  ? a_slice ^ b_slice :
              op == LOP_NAND ? ~(a_slice & b_slice) :
              op == LOP_XNOR ? ~(a_slice ^ b_slice) :
              op == LOP_ANDN ? a_slice & ~b_slice :
                               a_slice | ~b_slice;
endmodule

// File: rtl/bitwise_logic_unit_seq.sv
// bitwise_logic_unit_seq: multi-cycle bitwise logic unit, SLICE bits per clock, LSB first
module bitwise_logic_unit_seq
  import logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_zero
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (SLICE < 1 || SLICE > WIDTH || WIDTH % SLICE != 0) begin : g_bad_params
    $error("bitwise_logic_unit_seq: WIDTH must be a positive multiple of SLICE");
  end
  lu_state_e        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, res_nxt;
  logic [2:0]       op_r;
  logic [SLICE-1:0] c_slice;
  logic_slice #(.SLICE(SLICE)) u_slice (
    .op      (op_r),
    .a_slice (a_r[cnt*SLICE +: SLICE]),
    .b_slice (b_r[cnt*SLICE +: SLICE]),
    .c_slice (c_slice)
  );
  assign in_ready = state == LU_IDLE;
  // result with the current slice merged in, so the zero test sees the final value
  always_comb begin
    res_nxt = out_c;
    res_nxt[cnt*SLICE +: SLICE] = c_slice;
  end
  // control FSM with operand capture, slice write-back and registered flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LU_IDLE;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      out_c     <= '0;
      out_zero  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LU_IDLE: if (in_valid) begin
          a_r   <= in_a;
          b_r   <= in_b;
          op_r  <= op;
          cnt   <= '0;
          state <= LU_RUN;
        end
        LU_RUN: begin
          out_c <= res_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state     <= LU_DONE;
            out_valid <= 1'b1;
            out_zero  <= ~|res_nxt;
          end
        end
        LU_DONE: if (out_ready) begin
          state     <= LU_IDLE;
          out_valid <= 1'b0;
        end
        default: state <= LU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitwise_logic_unit_seq.sv
// tb_bitwise_logic_unit_seq: scoreboard bench over three parameterisations
module tb_bitwise_logic_unit_seq;
  typedef struct packed {logic [31:0] c; logic z;} exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  iv = '0, ordy = 3'b111, rdy, vld, zr;
  logic [31:0] oc [3];
  logic [31:0] oc1;
  logic [7:0]  oc2;
  exp_t        q [3][$];
  int          vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  bitwise_logic_unit_seq #(.WIDTH(32), .SLICE(8)) u_main (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]), .op(op),
    .in_a(a), .in_b(b), .out_valid(vld[0]), .out_ready(ordy[0]),
    .out_c(oc[0]), .out_zero(zr[0]));
  bitwise_logic_unit_seq #(.WIDTH(32), .SLICE(32)) u_wide (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]), .op(op),
    .in_a(a), .in_b(b), .out_valid(vld[1]), .out_ready(ordy[1]),
    .out_c(oc1), .out_zero(zr[1]));
  bitwise_logic_unit_seq #(.WIDTH(8), .SLICE(1)) u_bit (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy[2]), .op(op),
    .in_a(a[7:0]), .in_b(b[7:0]), .out_valid(vld[2]), .out_ready(ordy[2]),
    .out_c(oc2), .out_zero(zr[2]));
  assign oc[1] = oc1;
  assign oc[2] = {24'h0, oc2};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask
  // monitor: every completed handshake is checked against the oldest expectation
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && ordy[i]) begin
        if (q[i].size() == 0) chk($sformatf("unexpected_out[%0d]", i), 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q[i].pop_front();
          chk($sformatf("out_c[%0d]", i), oc[i], e.c);
          chk($sformatf("out_zero[%0d]", i), {31'd0, zr[i]}, {31'd0, e.z});
        end
      end
    end
  end
  task automatic issue(input int sel, input logic [2:0] o, input logic [31:0] ia, ib,
                       input logic [31:0] c, input logic z, input int lat);
    int t, n;
    t = 0;
    @(negedge clk);
    while (!rdy[sel] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("in_ready_wait[%0d]", sel), {31'd0, rdy[sel]}, 32'd1);
    op = o;
    a = ia;
    b = ib;
    iv[sel] = 1'b1;
    q[sel].push_back('{c: c, z: z});
    @(posedge clk);
    #1 iv[sel] = 1'b0;
    n = 0;
    while (!vld[sel] && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk($sformatf("latency[%0d]", sel), n, lat);
  endtask
  logic [2:0]  ops  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] exps [8] = '{32'hF0008181, 32'hFFF0E7E7, 32'h000F1818, 32'h0FF06666,
                            32'h0FFF7E7E, 32'hF00F9999, 32'h00F02424, 32'hF0FFBDBD};
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, rdy[0]}, 32'd1);
    chk("reset_out_valid", {31'd0, vld[0]}, 32'd0);
    chk("reset_out_c", oc[0], 32'd0);
    chk("reset_out_zero", {31'd0, zr[0]}, 32'd0);
    reset = 1'b0;
    issue(0, 3'd2, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4);
    issue(0, 3'd2, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 4);
    issue(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4);
    for (int i = 0; i < 8; i++) issue(0, ops[i], 32'hF0F0A5A5, 32'hFF00C3C3, exps[i], 1'b0, 4);
    repeat (2) @(posedge clk);
    #1 ordy[0] = 1'b0;
    issue(0, 3'd3, 32'hF0F0A5A5, 32'hFF00C3C3, 32'h0FF06666, 1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, vld[0]}, 32'd1);
      chk("hold_out_c", oc[0], 32'h0FF06666);
      chk("hold_in_ready", {31'd0, rdy[0]}, 32'd0);
      op = 3'd0;
      a = 32'h12345678;
      b = 32'h0;
      iv[0] = 1'b1;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    #1 ordy[0] = 1'b1;
    @(negedge clk);
    chk("release_in_ready_low", {31'd0, rdy[0]}, 32'd0);
    @(posedge clk);
    #1;
    chk("release_in_ready", {31'd0, rdy[0]}, 32'd1);
    chk("release_out_valid", {31'd0, vld[0]}, 32'd0);
    @(negedge clk);
    op = 3'd0;
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrun_out_valid", {31'd0, vld[0]}, 32'd0);
    chk("midrun_out_c", oc[0], 32'd0);
    chk("midrun_in_ready", {31'd0, rdy[0]}, 32'd1);
    chk("midrun_out_zero", {31'd0, zr[0]}, 32'd0);
    issue(0, 3'd7, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 4);
    issue(1, 3'd3, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1);
    issue(2, 3'd7, 32'h0000000F, 32'h000000F0, 32'h0000000F, 1'b0, 8);
    repeat (5) @(posedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("pending[%0d]", i), q[i].size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
